// File: rtl/micro_sequencer.sv
// micro_sequencer: control-address sequencer for a microprogrammed CPU.
// CAR=0 fetches and dispatches on the instruction word presented on MDB.
// Every other address either steps to CAR+1 or, at the end of a
// microsequence, returns to fetch (or enters the interrupt sequence).
// HOLD freezes CAR and IR for memory wait states or a debug halt.
module micro_sequencer #(
  parameter int CAR_BITS = 6
) (
  input  logic                MCLK,
  input  logic                RST_n,
  input  logic [15:0]         MDB,
  input  logic                HOLD,
  input  logic                IRQ,
  input  logic                GIE,
  output logic [CAR_BITS-1:0] CAR,
  output logic [15:0]         IR,
  output logic                IFETCH,
  output logic                ILLEGAL
);

  typedef logic [CAR_BITS-1:0] car_t;

  // Addressing-mode class of the source operand; selects one of three
  // microsequence entry points for each instruction family.
  typedef enum logic [1:0] {
    SRC_REG,
    SRC_IND,
    SRC_IDX
  } src_class_e;

  localparam car_t CAR_FETCH     = car_t'(0);
  localparam car_t CAR_RETI      = car_t'(50);
  localparam car_t CAR_IRQ_ENTRY = car_t'(54);
  localparam car_t CAR_IRQ_LAST  = car_t'(58);
  localparam car_t CAR_JUMP      = car_t'(59);

  // As=11 with Rs=0 is the immediate form, which is sequenced like indexed.
  function automatic src_class_e src_class(input logic [1:0] as_f,
                                           input logic [3:0] rs);
    case (as_f)
      2'b00:   return SRC_REG;
      2'b10:   return SRC_IND;
      2'b01:   return SRC_IDX;
      default: return (rs == 4'd0) ? SRC_IDX : SRC_IND;
    endcase
  endfunction

  function automatic car_t pick_entry(input src_class_e cls,
                                      input car_t a_reg,
                                      input car_t a_ind,
                                      input car_t a_idx);
    case (cls)
      SRC_REG: return a_reg;
      SRC_IND: return a_ind;
      default: return a_idx;
    endcase
  endfunction

  // Last microinstruction of each sequence; IRQ is sampled only here.
  function automatic logic is_end(input car_t a);
    case (int'(a))
      1, 5, 7, 12, 15, 21, 22, 25, 29, 32, 35, 39, 42, 45, 49, 53, 58, 59:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  car_t       r_car;
  logic [15:0] r_ir;
  logic       r_illegal;

  car_t       w_dispatch;
  car_t       w_car_next;
  logic       w_illegal;
  src_class_e w_src_single;
  src_class_e w_src_dual;

  // Decode the word on MDB into the first microaddress of its sequence.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_dispatch   = CAR_FETCH;
    w_illegal    = 1'b0;
    w_src_single = src_class(MDB[5:4], MDB[3:0]);
    w_src_dual   = src_class(MDB[5:4], MDB[11:8]);
    if (MDB[15:13] == 3'b001) begin
      w_dispatch = CAR_JUMP;
    end else if (MDB == 16'h1300) begin
      w_dispatch = CAR_RETI;
    end else if (MDB[15:7] == 9'h024) begin
      w_dispatch = pick_entry(w_src_single, car_t'(30), car_t'(33), car_t'(36));
    end else if (MDB[15:7] == 9'h025) begin
      w_dispatch = pick_entry(w_src_single, car_t'(40), car_t'(43), car_t'(46));
    end else if (MDB[15:10] == 6'b000100 && MDB[9:7] <= 3'd3) begin
      w_dispatch = pick_entry(w_src_single, car_t'(22), car_t'(23), car_t'(26));
    end else if (MDB[15:12] >= 4'd4) begin
      if (MDB[7]) begin
        w_dispatch = pick_entry(w_src_dual, car_t'(2), car_t'(8), car_t'(16));
      end else begin
        w_dispatch = pick_entry(w_src_dual, car_t'(1), car_t'(6), car_t'(13));
      end
    end else begin
      w_illegal = 1'b1;
    end
  end

  // Choose the next control address from the current one.
  always_comb begin
    w_car_next = CAR_FETCH;
    if (r_car == CAR_FETCH) begin
      w_car_next = w_dispatch;
    end else if (r_car > CAR_JUMP) begin
      w_car_next = CAR_FETCH;
    end else if (r_car == CAR_IRQ_LAST) begin
      w_car_next = CAR_FETCH;
    end else if (is_end(r_car)) begin
      w_car_next = (IRQ && GIE) ? CAR_IRQ_ENTRY : CAR_FETCH;
    end else begin
      w_car_next = r_car + car_t'(1);
    end
  end

  // Sequencer state: CAR and IR advance only on non-HOLD edges; ILLEGAL is a
  // one-cycle pulse following an undecodable fetch.
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      r_car     <= CAR_FETCH;
      r_ir      <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      r_illegal <= 1'b0;
      if (!HOLD) begin
        r_car <= w_car_next;
        if (r_car == CAR_FETCH) begin
          r_ir      <= MDB;
          r_illegal <= w_illegal;
        end
      end
    end
  end

  assign CAR     = r_car;
  assign IR      = r_ir;
  assign ILLEGAL = r_illegal;
  assign IFETCH  = (r_car == CAR_FETCH);

endmodule
